// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared writeback source codes, register address width and FSM states
package wb_pkg;

  localparam int REG_AW = 4;
  localparam int SRC_W  = 3;

  typedef enum logic [SRC_W-1:0] {
    SRC_NONE   = 3'b000,
    SRC_ALU    = 3'b001,
    SRC_MEM    = 3'b010,
    SRC_IMM    = 3'b011,
    SRC_PARITY = 3'b100
  } wb_src_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WAIT_MEM
  } wb_state_e;

  // Sources whose data is already on the mux input when the request arrives.
  function automatic logic src_is_direct(input logic [SRC_W-1:0] src);
    return (src == SRC_ALU) || (src == SRC_IMM) || (src == SRC_PARITY);
  endfunction

  function automatic logic src_is_illegal(input logic [SRC_W-1:0] src);
    return src > SRC_PARITY;
  endfunction

endpackage

// File: rtl/wb_source_ctrl_if.sv
// rtl/wb_source_ctrl_if.sv - request, memory-valid and register-write signals of the writeback controller
interface wb_source_ctrl_if;
  import wb_pkg::*;

  logic              req_valid;
  logic [SRC_W-1:0]  req_src;
  logic [REG_AW-1:0] req_rd;
  logic              req_ready;
  logic              mem_valid;
  logic [SRC_W-1:0]  wb_sel;
  logic              reg_we;
  logic [REG_AW-1:0] reg_waddr;
  logic              wb_err;

  modport master (
    output req_valid, req_src, req_rd, mem_valid,
    input  req_ready, wb_sel, reg_we, reg_waddr, wb_err
  );

  modport slave (
    input  req_valid, req_src, req_rd, mem_valid,
    output req_ready, wb_sel, reg_we, reg_waddr, wb_err
  );

endinterface

// File: rtl/wb_timeout_cnt.sv
// rtl/wb_timeout_cnt.sv - WAIT_MEM cycle counter; expire is high during the LIMIT-th enabled cycle
module wb_timeout_cnt #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  logic [7:0] count_q, count_d;

  assign expire_o = enable_i && (count_q == 8'(LIMIT - 1));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expire_o) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_source_ctrl.sv
// rtl/wb_source_ctrl.sv - writeback source controller: selects the register-input mux and issues one write per request
// Define WB_SRC_TIMEOUT_EN to abort WAIT_MEM after MEM_TIMEOUT cycles without mem_valid.
module wb_source_ctrl
  import wb_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst_n,
  wb_source_ctrl_if.slave   bus
);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
    $error("wb_source_ctrl: MEM_TIMEOUT must be in 1..255");
  end

  wb_state_e         state_q, state_d;
  logic [SRC_W-1:0]  src_q, src_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic              err_q, err_d;
  logic              accept;
  logic              timeout_exp;

  assign accept = bus.req_valid && (state_q == ST_IDLE);

`ifdef WB_SRC_TIMEOUT_EN
  logic cnt_clear;
  assign cnt_clear = accept && (bus.req_src == SRC_MEM);

  wb_timeout_cnt #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (cnt_clear),
    .enable_i (state_q == ST_WAIT_MEM),
    .expire_o (timeout_exp)
  );
`else
  assign timeout_exp = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    waddr_d       = waddr_q;
    err_d         = 1'b0;
    bus.req_ready = 1'b0;
    bus.wb_sel    = SRC_NONE;
    bus.reg_we    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) begin
          src_d   = bus.req_src;
          waddr_d = bus.req_rd;
          if (src_is_direct(bus.req_src)) begin
            state_d = ST_WRITE;
          end else if (bus.req_src == SRC_MEM) begin
            state_d = ST_WAIT_MEM;
          end else if (src_is_illegal(bus.req_src)) begin
            err_d = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        bus.wb_sel = src_q;
        bus.reg_we = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_WAIT_MEM: begin
        bus.wb_sel = src_q;
        bus.reg_we = bus.mem_valid;
        // Data arriving on the expiry cycle still wins over the timeout.
        if (bus.mem_valid) begin
          state_d = ST_IDLE;
        end else if (timeout_exp) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.reg_waddr = waddr_q;
  assign bus.wb_err    = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      waddr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      waddr_q <= waddr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_source_ctrl.sv
// tb/tb_wb_source_ctrl.sv - cycle-table and scoreboard bench for wb_source_ctrl
module tb_wb_source_ctrl;

  typedef struct packed {
    logic       ready;
    logic [2:0] sel;
    logic       we;
    logic [3:0] waddr;
    logic       err;
  } out_t;

  typedef struct {
    logic       rv;
    logic [2:0] src;
    logic [3:0] rd;
    logic       mv;
    out_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  out_t  exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  wb_source_ctrl_if bus ();

  wb_source_ctrl #(
    .MEM_TIMEOUT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic out_t mk(input logic r, input logic [2:0] s, input logic w,
                              input logic [3:0] a, input logic e);
    out_t o;
    o.ready = r; o.sel = s; o.we = w; o.waddr = a; o.err = e;
    return o;
  endfunction

  function automatic vec_t mkv(input logic rv, input logic [2:0] src, input logic [3:0] rd,
                               input logic mv, input out_t e);
    vec_t v;
    v.rv = rv; v.src = src; v.rd = rd; v.mv = mv; v.exp = e;
    return v;
  endfunction

  task automatic drive(input logic rv, input logic [2:0] src, input logic [3:0] rd, input logic mv);
    bus.req_valid = rv;
    bus.req_src   = src;
    bus.req_rd    = rd;
    bus.mem_valid = mv;
  endtask

  task automatic push(input out_t e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic pop_check();
    out_t  e, a;
    string nm;
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    a  = mk(bus.req_ready, bus.wb_sel, bus.reg_we, bus.reg_waddr, bus.wb_err);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got ready=%0b sel=%0d we=%0b waddr=%0d err=%0b, want ready=%0b sel=%0d we=%0b waddr=%0d err=%0b",
               nm, a.ready, a.sel, a.we, a.waddr, a.err, e.ready, e.sel, e.we, e.waddr, e.err);
    end
  endtask

  task automatic step(input logic rv, input logic [2:0] src, input logic [3:0] rd,
                      input logic mv, input out_t e, input string nm);
    @(posedge clk);
    #1;
    drive(rv, src, rd, mv);
    push(e, nm);
    @(negedge clk);
    pop_check();
  endtask

  vec_t vecs[21];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ALU, MEM latency 3, stray mem_valid, illegal/none codes, back-to-back IMM/PARITY, illegal pair
    vecs[0]  = mkv(1, 3'b001, 4'd5, 0, mk(1, 0, 0, 4'd0, 0));
    vecs[1]  = mkv(0, 3'b000, 4'd0, 0, mk(0, 1, 1, 4'd5, 0));
    vecs[2]  = mkv(0, 3'b000, 4'd0, 0, mk(1, 0, 0, 4'd5, 0));
    vecs[3]  = mkv(1, 3'b010, 4'd2, 0, mk(1, 0, 0, 4'd5, 0));
    vecs[4]  = mkv(0, 3'b000, 4'd0, 0, mk(0, 2, 0, 4'd2, 0));
    vecs[5]  = mkv(0, 3'b000, 4'd0, 0, mk(0, 2, 0, 4'd2, 0));
    vecs[6]  = mkv(0, 3'b000, 4'd0, 1, mk(0, 2, 1, 4'd2, 0));
    vecs[7]  = mkv(0, 3'b000, 4'd0, 1, mk(1, 0, 0, 4'd2, 0));
    vecs[8]  = mkv(1, 3'b110, 4'd9, 0, mk(1, 0, 0, 4'd2, 0));
    vecs[9]  = mkv(0, 3'b000, 4'd0, 0, mk(1, 0, 0, 4'd9, 1));
    vecs[10] = mkv(1, 3'b000, 4'd3, 0, mk(1, 0, 0, 4'd9, 0));
    vecs[11] = mkv(0, 3'b000, 4'd0, 0, mk(1, 0, 0, 4'd3, 0));
    vecs[12] = mkv(1, 3'b011, 4'd1, 0, mk(1, 0, 0, 4'd3, 0));
    vecs[13] = mkv(1, 3'b100, 4'd7, 0, mk(0, 3, 1, 4'd1, 0));
    vecs[14] = mkv(1, 3'b100, 4'd7, 0, mk(1, 0, 0, 4'd1, 0));
    vecs[15] = mkv(0, 3'b000, 4'd0, 0, mk(0, 4, 1, 4'd7, 0));
    vecs[16] = mkv(0, 3'b000, 4'd0, 0, mk(1, 0, 0, 4'd7, 0));
    vecs[17] = mkv(1, 3'b101, 4'd4, 0, mk(1, 0, 0, 4'd7, 0));
    vecs[18] = mkv(1, 3'b111, 4'd6, 0, mk(1, 0, 0, 4'd4, 1));
    vecs[19] = mkv(0, 3'b000, 4'd0, 0, mk(1, 0, 0, 4'd6, 1));
    vecs[20] = mkv(0, 3'b000, 4'd0, 0, mk(1, 0, 0, 4'd6, 0));

    drive(1, 3'b001, 4'd15, 1);
    #3;
    push(mk(1, 0, 0, 4'd0, 0), "reset_state");
    pop_check();
    @(negedge clk);
    drive(0, 3'b000, 4'd0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].rv, vecs[i].src, vecs[i].rd, vecs[i].mv, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Reset one cycle into WAIT_MEM, then late mem_valid must not write
    step(1, 3'b010, 4'd10, 0, mk(1, 0, 0, 4'd6, 0), "rst_accept");
    step(0, 3'b000, 4'd0, 0, mk(0, 2, 0, 4'd10, 0), "rst_wait");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    push(mk(1, 0, 0, 4'd0, 0), "rst_async");
    pop_check();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 3'b000, 4'd0, 1, mk(1, 0, 0, 4'd0, 0), "rst_late_mv0");
    step(0, 3'b000, 4'd0, 1, mk(1, 0, 0, 4'd0, 0), "rst_late_mv1");

`ifdef WB_SRC_TIMEOUT_EN
    step(1, 3'b010, 4'd12, 0, mk(1, 0, 0, 4'd0, 0), "to_accept");
    for (int i = 0; i < 4; i++) begin
      step(0, 3'b000, 4'd0, 0, mk(0, 2, 0, 4'd12, 0), $sformatf("to_wait%0d", i));
    end
    step(0, 3'b000, 4'd0, 0, mk(1, 0, 0, 4'd12, 1), "to_err");
    step(0, 3'b000, 4'd0, 0, mk(1, 0, 0, 4'd12, 0), "to_err_clear");
    step(1, 3'b010, 4'd13, 0, mk(1, 0, 0, 4'd12, 0), "edge_accept");
    for (int i = 0; i < 3; i++) begin
      step(0, 3'b000, 4'd0, 0, mk(0, 2, 0, 4'd13, 0), $sformatf("edge_wait%0d", i));
    end
    step(0, 3'b000, 4'd0, 1, mk(0, 2, 1, 4'd13, 0), "edge_write");
    step(0, 3'b000, 4'd0, 0, mk(1, 0, 0, 4'd13, 0), "edge_no_err");
`else
    step(1, 3'b010, 4'd12, 0, mk(1, 0, 0, 4'd0, 0), "nto_accept");
    for (int i = 0; i < 20; i++) begin
      step(0, 3'b000, 4'd0, 0, mk(0, 2, 0, 4'd12, 0), $sformatf("nto_wait%0d", i));
    end
    step(0, 3'b000, 4'd0, 1, mk(0, 2, 1, 4'd12, 0), "nto_write");
    step(0, 3'b000, 4'd0, 0, mk(1, 0, 0, 4'd12, 0), "nto_idle");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_source_ctrl.md
WB_SOURCE_CTRL -- requirements
Module: wb_source_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, giving the maximum WAIT_MEM cycles before abort (range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port req_valid  input  1  writeback request present.
REQ-005 SHALL have port req_src  input  3  source code: 000 none, 001 ALU, 010 MEM, 011 IMM, 100 PARITY.
REQ-006 SHALL have port req_rd  input  4  destination register address.
REQ-007 SHALL have port req_ready  output  1  controller can accept a request.
REQ-008 SHALL have port mem_valid  input  1  memory read data valid on the mux mem input.
REQ-009 SHALL have port wb_sel  output  3  select driven to the register-input source mux.
REQ-010 SHALL have port reg_we  output  1  register file write enable.
REQ-011 SHALL have port reg_waddr  output  4  register file write address.
REQ-012 SHALL have port wb_err  output  1  one-cycle pulse: illegal source code or memory timeout.

Function
REQ-013 SHALL implement FSM states IDLE, WRITE, WAIT_MEM.
REQ-014 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid && req_ready at a rising edge.
REQ-015 On acceptance, SHALL register req_src into the select register and req_rd into reg_waddr.
REQ-016 Accepted src 001/011/100 SHALL go to WRITE; WRITE SHALL assert reg_we for exactly one cycle, then return to IDLE (accept-to-write latency 1 cycle).
REQ-017 Accepted src 010 SHALL go to WAIT_MEM and clear the timeout counter.
REQ-018 In WAIT_MEM, reg_we SHALL equal mem_valid combinationally; the first cycle with mem_valid=1 SHALL write and return to IDLE next edge.
REQ-019 Accepted src 000 SHALL be a no-op: no write, no error, remain in IDLE.
REQ-020 Accepted src 101..111 SHALL pulse wb_err the next cycle, perform no write, and remain in IDLE.
REQ-021 wb_sel SHALL equal the registered source in WRITE and WAIT_MEM, and 000 in IDLE.
REQ-022 reg_we SHALL never be asserted in IDLE; at most one write per accepted request.
REQ-023 mem_valid outside WAIT_MEM SHALL be ignored.
REQ-024 A mem_valid arriving in the same cycle the timeout expires SHALL take priority: the write occurs, no error.

Reset
REQ-025 rst_n=0 SHALL force, asynchronously: state IDLE, wb_sel=000, reg_we=0, reg_waddr=0, wb_err=0, timeout counter=0; req_ready=1 after deassertion.
REQ-026 Reset during WAIT_MEM or WRITE SHALL abandon the request with no write.

Configuration
REQ-027 Macro WB_SRC_TIMEOUT_EN defined: WAIT_MEM counts cycles; after MEM_TIMEOUT cycles without mem_valid, SHALL pulse wb_err, perform no write, and return to IDLE.
REQ-028 WB_SRC_TIMEOUT_EN undefined: no counter is built; WAIT_MEM waits indefinitely for mem_valid and wb_err fires only for illegal codes.

Structure
REQ-029 The source codes (as an enum typedef), the 4-bit register address width, and the FSM state typedef SHALL live in a shared package wb_pkg, used by this block and the source mux.
REQ-030 The timeout counter SHALL be a sub-module wb_timeout_cnt (clear, enable, expire), instantiated only under WB_SRC_TIMEOUT_EN.

Verification
REQ-031 ALU write: req_valid=1, src=001, rd=5 at cycle 0 -> cycle 1: wb_sel=001, reg_we=1, reg_waddr=5; cycle 2: IDLE, req_ready=1.
REQ-032 MEM write, latency 3: src=010, rd=2, mem_valid high at 3rd WAIT_MEM cycle -> wb_sel=010 throughout, single reg_we that cycle, req_ready low until the write completes.
REQ-033 Illegal code: src=110 -> wb_err pulses 1 cycle, reg_we stays 0, req_ready stays 1; src=000 -> nothing asserted.
REQ-034 Timeout (WB_SRC_TIMEOUT_EN, MEM_TIMEOUT=4): src=010, mem_valid held 0 -> wb_err after 4 WAIT_MEM cycles, no write, IDLE; same build with mem_valid in cycle 4 -> write, no error.
REQ-035 Reset mid-WAIT_MEM: rst_n low for 1 cycle during WAIT_MEM -> all outputs reset immediately, later mem_valid causes no write.
REQ-036 Back-to-back: IMM rd=1 then PARITY rd=7 with req_valid held -> writes on cycles 1 and 3, second request accepted at cycle 2.
